// File: rtl/mips_pkg.sv
// Shared MIPS control encodings: opcodes, ALU ops, mux selects and the
// multicycle controller state type.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] SRCB_RT    = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_EXECUTE,
      S_ALUWB,
      S_BRANCH,
      S_ADDIEXEC,
      S_ADDIWB,
      S_JUMP
   } mc_state_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller (master) and the
// datapath/memory side (slave).
interface multicycle_controller_if;
   logic [5:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       mem_req;
   logic       iord;
   logic       memwrite;
   logic       irwrite;
   logic       pcwrite;
   logic       branch;
   logic [1:0] pcsrc;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [1:0] aluop;
   logic       regwrite;
   logic       regdst;
   logic       memtoreg;
   logic       retire;
   logic       illegal_op;
   logic       mem_timeout;

   modport master (
      input  opcode, mem_ready,
      output mem_req, iord, memwrite, irwrite, pcwrite, branch,
      output pcsrc, alusrca, alusrcb, aluop, regwrite, regdst,
      output memtoreg, retire, illegal_op, mem_timeout
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  mem_req, iord, memwrite, irwrite, pcwrite, branch,
      input  pcsrc, alusrca, alusrcb, aluop, regwrite, regdst,
      input  memtoreg, retire, illegal_op, mem_timeout
   );
endinterface

// File: rtl/mc_wait_timer.sv
// Saturating count of consecutive unanswered memory wait cycles; hit marks
// the abort threshold (disabled when MEM_TIMEOUT is 0).
module mc_wait_timer #(
   parameter int MEM_TIMEOUT = 15,
   parameter int TW          = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic inc_i,
   output logic hit_o
);

   localparam logic [TW-1:0] LIMIT = TW'(MEM_TIMEOUT);
   localparam logic [TW-1:0] MAXC  = '1;

   logic [TW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (inc_i && cnt_q != MAXC)
         cnt_d = cnt_q + TW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign hit_o = (cnt_q == LIMIT) && (MEM_TIMEOUT != 0);

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM with memory ready handshake, bounded wait
// timeout, retire pulse and illegal-opcode flag.
module multicycle_controller
   import mips_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int TW          = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   multicycle_controller_if.master bus
);

   mc_state_t state_q, state_d;
   logic      req_st;
   logic      mem_wait;
   logic      hit;
   logic      to;

   assign req_st   = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                     (state_q == S_MEMWR);
   assign mem_wait = req_st && !bus.mem_ready;
   assign to       = hit && mem_wait && !reset;

   mc_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .TW          (TW)
   ) u_timer (
      .clk   (clk),
      .reset (reset),
      .clr_i ((state_d != state_q) || to),
      .inc_i (mem_wait),
      .hit_o (hit)
   );

   always_ff @(posedge clk) begin
      if (reset)
         state_q <= S_FETCH;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d         = state_q;
      bus.mem_req     = 1'b0;
      bus.iord        = 1'b0;
      bus.memwrite    = 1'b0;
      bus.irwrite     = 1'b0;
      bus.pcwrite     = 1'b0;
      bus.branch      = 1'b0;
      bus.pcsrc       = PCSRC_ALU;
      bus.alusrca     = 1'b0;
      bus.alusrcb     = SRCB_RT;
      bus.aluop       = ALUOP_ADD;
      bus.regwrite    = 1'b0;
      bus.regdst      = 1'b0;
      bus.memtoreg    = 1'b0;
      bus.retire      = 1'b0;
      bus.illegal_op  = 1'b0;
      bus.mem_timeout = 1'b0;
      if (!reset) begin
         unique case (state_q)
            S_FETCH: begin
               bus.mem_req = 1'b1;
               bus.alusrcb = SRCB_FOUR;
               bus.irwrite = bus.mem_ready;
               bus.pcwrite = bus.mem_ready;
               if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
               bus.alusrcb = SRCB_IMMSH;
               case (bus.opcode)
                  OP_RTYPE: state_d = S_EXECUTE;
                  OP_LW,
                  OP_SW:    state_d = S_MEMADR;
                  OP_BEQ:   state_d = S_BRANCH;
                  OP_ADDI:  state_d = S_ADDIEXEC;
                  OP_J:     state_d = S_JUMP;
                  default: begin
                     bus.illegal_op = 1'b1;
                     state_d        = S_FETCH;
                  end
               endcase
            end
            S_MEMADR: begin
               bus.alusrca = 1'b1;
               bus.alusrcb = SRCB_IMM;
               state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
               bus.mem_req = 1'b1;
               bus.iord    = 1'b1;
               if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
               bus.regwrite = 1'b1;
               bus.memtoreg = 1'b1;
               bus.retire   = 1'b1;
               state_d      = S_FETCH;
            end
            S_MEMWR: begin
               bus.mem_req  = 1'b1;
               bus.iord     = 1'b1;
               bus.memwrite = 1'b1;
               bus.retire   = bus.mem_ready;
               if (bus.mem_ready) state_d = S_FETCH;
            end
            S_EXECUTE: begin
               bus.alusrca = 1'b1;
               bus.aluop   = ALUOP_FUNCT;
               state_d     = S_ALUWB;
            end
            S_ALUWB: begin
               bus.regwrite = 1'b1;
               bus.regdst   = 1'b1;
               bus.retire   = 1'b1;
               state_d      = S_FETCH;
            end
            S_BRANCH: begin
               bus.alusrca = 1'b1;
               bus.aluop   = ALUOP_SUB;
               bus.pcsrc   = PCSRC_ALUOUT;
               bus.branch  = 1'b1;
               bus.retire  = 1'b1;
               state_d     = S_FETCH;
            end
            S_ADDIEXEC: begin
               bus.alusrca = 1'b1;
               bus.alusrcb = SRCB_IMM;
               state_d     = S_ADDIWB;
            end
            S_ADDIWB: begin
               bus.regwrite = 1'b1;
               bus.retire   = 1'b1;
               state_d      = S_FETCH;
            end
            S_JUMP: begin
               bus.pcsrc   = PCSRC_JUMP;
               bus.pcwrite = 1'b1;
               bus.retire  = 1'b1;
               state_d     = S_FETCH;
            end
            default: state_d = S_FETCH;
         endcase
         // Abort overrides the state decode; irwrite/pcwrite/retire are already 0
         if (to) begin
            bus.mem_timeout = 1'b1;
            state_d         = S_FETCH;
         end
      end
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller (MEM_TIMEOUT=4): per-cycle check
// of the full control word against hand-derived vectors.
module tb_multicycle_controller;

   logic clk;
   logic reset;

   multicycle_controller_if bus();

   multicycle_controller #(
      .MEM_TIMEOUT (4),
      .TW          (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // mem_req iord memwrite irwrite pcwrite branch pcsrc[2] alusrca
   // alusrcb[2] aluop[2] regwrite regdst memtoreg retire illegal timeout
   wire [18:0] obs = {bus.mem_req, bus.iord, bus.memwrite, bus.irwrite,
                      bus.pcwrite, bus.branch, bus.pcsrc, bus.alusrca,
                      bus.alusrcb, bus.aluop, bus.regwrite, bus.regdst,
                      bus.memtoreg, bus.retire, bus.illegal_op,
                      bus.mem_timeout};

   localparam logic [18:0] V_RST  = 19'b0_0_0_0_0_0_00_0_00_00_0_0_0_0_0_0;
   localparam logic [18:0] V_F_R  = 19'b1_0_0_1_1_0_00_0_01_00_0_0_0_0_0_0;
   localparam logic [18:0] V_F_W  = 19'b1_0_0_0_0_0_00_0_01_00_0_0_0_0_0_0;
   localparam logic [18:0] V_F_TO = 19'b1_0_0_0_0_0_00_0_01_00_0_0_0_0_0_1;
   localparam logic [18:0] V_DEC  = 19'b0_0_0_0_0_0_00_0_11_00_0_0_0_0_0_0;
   localparam logic [18:0] V_ILL  = 19'b0_0_0_0_0_0_00_0_11_00_0_0_0_0_1_0;
   localparam logic [18:0] V_MA   = 19'b0_0_0_0_0_0_00_1_10_00_0_0_0_0_0_0;
   localparam logic [18:0] V_MR   = 19'b1_1_0_0_0_0_00_0_00_00_0_0_0_0_0_0;
   localparam logic [18:0] V_MRTO = 19'b1_1_0_0_0_0_00_0_00_00_0_0_0_0_0_1;
   localparam logic [18:0] V_MWB  = 19'b0_0_0_0_0_0_00_0_00_00_1_0_1_1_0_0;
   localparam logic [18:0] V_MW_W = 19'b1_1_1_0_0_0_00_0_00_00_0_0_0_0_0_0;
   localparam logic [18:0] V_MW_R = 19'b1_1_1_0_0_0_00_0_00_00_0_0_0_1_0_0;
   localparam logic [18:0] V_EX   = 19'b0_0_0_0_0_0_00_1_00_10_0_0_0_0_0_0;
   localparam logic [18:0] V_AWB  = 19'b0_0_0_0_0_0_00_0_00_00_1_1_0_1_0_0;
   localparam logic [18:0] V_BR   = 19'b0_0_0_0_0_1_01_1_00_01_0_0_0_1_0_0;
   localparam logic [18:0] V_AIX  = 19'b0_0_0_0_0_0_00_1_10_00_0_0_0_0_0_0;
   localparam logic [18:0] V_AIWB = 19'b0_0_0_0_0_0_00_0_00_00_1_0_0_1_0_0;
   localparam logic [18:0] V_J    = 19'b0_0_0_0_1_0_10_0_00_00_0_0_0_1_0_0;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic step(input string tag, input logic [18:0] exp);
      #1;
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset         = 1'b1;
      bus.mem_ready = 1'b1;
      bus.opcode    = 6'b100011;
      bus.zero      = 1'b0;
      @(posedge clk);
      #1;
      step("rst_c1", V_RST);
      step("rst_c2", V_RST);
      step("rst_c3", V_RST);
      reset = 1'b0;

      // lw, zero-wait: 5 cycles
      step("lw_fetch", V_F_R);
      step("lw_dec", V_DEC);
      step("lw_madr", V_MA);
      step("lw_memrd", V_MR);
      step("lw_memwb", V_MWB);

      // sw with 3 wait cycles
      bus.opcode = 6'b101011;
      step("sw_fetch", V_F_R);
      step("sw_dec", V_DEC);
      step("sw_madr", V_MA);
      bus.mem_ready = 1'b0;
      step("sw_wait1", V_MW_W);
      step("sw_wait2", V_MW_W);
      step("sw_wait3", V_MW_W);
      bus.mem_ready = 1'b1;
      step("sw_done", V_MW_R);

      // R-type
      bus.opcode = 6'b000000;
      step("r_fetch", V_F_R);
      step("r_dec", V_DEC);
      step("r_exec", V_EX);
      step("r_aluwb", V_AWB);

      // addi
      bus.opcode = 6'b001000;
      step("addi_fetch", V_F_R);
      step("addi_dec", V_DEC);
      step("addi_exec", V_AIX);
      step("addi_wb", V_AIWB);

      // beq then j
      bus.opcode = 6'b000100;
      step("beq_fetch", V_F_R);
      step("beq_dec", V_DEC);
      step("beq_branch", V_BR);
      bus.opcode = 6'b000010;
      step("j_fetch", V_F_R);
      step("j_dec", V_DEC);
      step("j_jump", V_J);

      // illegal opcode
      bus.opcode = 6'b111111;
      step("ill_fetch", V_F_R);
      step("ill_dec", V_ILL);

      // lw with memory stuck: abort on the 5th MEMRD cycle
      bus.opcode = 6'b100011;
      step("to_fetch", V_F_R);
      step("to_dec", V_DEC);
      step("to_madr", V_MA);
      bus.mem_ready = 1'b0;
      step("to_rd1", V_MR);
      step("to_rd2", V_MR);
      step("to_rd3", V_MR);
      step("to_rd4", V_MR);
      step("to_rd5", V_MRTO);
      bus.mem_ready = 1'b1;
      step("to_refetch", V_F_R);

      // same, but ready arrives on the threshold cycle
      step("rdy_dec", V_DEC);
      step("rdy_madr", V_MA);
      bus.mem_ready = 1'b0;
      step("rdy_rd1", V_MR);
      step("rdy_rd2", V_MR);
      step("rdy_rd3", V_MR);
      step("rdy_rd4", V_MR);
      bus.mem_ready = 1'b1;
      step("rdy_rd5", V_MR);
      step("rdy_memwb", V_MWB);

      // fetch timeout re-issues the fetch
      bus.mem_ready = 1'b0;
      step("fto_w1", V_F_W);
      step("fto_w2", V_F_W);
      step("fto_w3", V_F_W);
      step("fto_w4", V_F_W);
      step("fto_w5", V_F_TO);
      step("fto_again", V_F_W);
      bus.mem_ready = 1'b1;
      step("fto_fetch", V_F_R);
      step("fto_dec", V_DEC);
      step("fto_madr", V_MA);
      step("fto_memrd", V_MR);
      step("fto_memwb", V_MWB);

      // reset in the middle of an R-type
      bus.opcode = 6'b000000;
      step("mr_fetch", V_F_R);
      step("mr_dec", V_DEC);
      reset = 1'b1;
      step("mr_rst", V_RST);
      reset = 1'b0;
      step("mr_fetch2", V_F_R);
      step("mr_dec2", V_DEC);
      step("mr_exec", V_EX);
      step("mr_aluwb", V_AWB);
      step("mr_fetch3", V_F_R);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
